// File: rtl/ccff_tail_checker_if.sv
// Readback word channel of the ccff tail checker.
// The checker drives rd_data/rd_valid; the consumer returns rd_ready.
interface ccff_tail_checker_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/ccff_tail_checker.sv
// Receive end of the configuration-chain marker test: skips the chain fill, checks the tail stream
// against the periodic head marker and deserializes the checked bits into readback words.
module ccff_tail_checker #(
    parameter int BS_LGT    = 8387,
    parameter int PERIOD    = 20,
    parameter int CHECK_LEN = 8440,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                start,
    input  logic                shift_en,
    input  logic                ccff_tail,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [CNT_W-1:0]    first_err,
    output logic                overflow,
    ccff_tail_checker_if.master rd
);
    localparam int PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int WP_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(BS_LGT - 1);
    localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(CHECK_LEN - 1);
    localparam logic [CNT_W-1:0] ALL_ONES   = '1;
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(PERIOD - 1);
    localparam logic [WP_W-1:0]  WP_LAST    = WP_W'(WORD_W - 1);

    typedef enum logic [1:0] {IDLE, FLUSH, CHECK, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [WP_W-1:0]     wpos_q, wpos_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]    first_err_q, first_err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                overflow_q, overflow_d;
    logic [WORD_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    logic                sample;
    logic                mismatch;
    logic                word_done;
    logic                last_bit;
    logic                hs;
    logic [WORD_W-1:0]   word_new;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        wpos_d      = wpos_q;
        shreg_d     = shreg_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        overflow_d  = overflow_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;

        // Expected marker bit is 1 only on the last phase of each period.
        sample    = (state_q == CHECK) && shift_en;
        mismatch  = sample && (ccff_tail != (phase_q == PH_LAST));
        word_done = sample && (wpos_q == WP_LAST);
        last_bit  = sample && (cnt_q == CHECK_LAST);
        hs        = rd_valid_q && rd.rd_ready;
        word_new  = shreg_q;
        word_new[wpos_q] = ccff_tail;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = FLUSH;
                    cnt_d       = '0;
                    phase_d     = '0;
                    wpos_d      = '0;
                    shreg_d     = '0;
                    err_cnt_d   = '0;
                    first_err_d = ALL_ONES;
                    overflow_d  = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            FLUSH: begin
                if (shift_en) begin
                    if (cnt_q == FLUSH_LAST) begin
                        state_d = CHECK;
                        cnt_d   = '0;
                        phase_d = '0;
                        wpos_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (shift_en) begin
                    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                    wpos_d  = word_done ? '0 : wpos_q + 1'b1;
                    shreg_d = word_new;
                    if (mismatch) begin
                        if (err_cnt_q != ALL_ONES) err_cnt_d = err_cnt_q + 1'b1;
                        if (err_cnt_q == '0) first_err_d = cnt_q;
                    end
                    if (last_bit) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Single-entry holding register: a word completing against an unaccepted one is dropped.
        if (word_done) begin
            if (!rd_valid_q || hs) begin
                rd_data_d  = word_new;
                rd_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (hs) begin
            rd_valid_d = 1'b0;
        end

        if (last_bit) pass_d = (err_cnt_d == '0) && !overflow_d;
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= '0;
            wpos_q      <= '0;
            shreg_q     <= '0;
            err_cnt_q   <= '0;
            first_err_q <= ALL_ONES;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            overflow_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            wpos_q      <= wpos_d;
            shreg_q     <= shreg_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            overflow_q  <= overflow_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_cnt     = err_cnt_q;
    assign first_err   = first_err_q;
    assign overflow    = overflow_q;
    assign rd.rd_data  = rd_data_q;
    assign rd.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_ccff_tail_checker.sv
// Scoreboard bench for ccff_tail_checker: stimulus queues expected words and run results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ccff_tail_checker;
    localparam int BS = 10;
    localparam int PER = 4;
    localparam int CL = 16;
    localparam int WW = 8;
    localparam int CW = 16;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          start;
    logic          shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          pass;
    logic          overflow;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] first_err;

    ccff_tail_checker_if #(.WORD_W(WW)) rd_if();

    ccff_tail_checker #(
        .BS_LGT(BS), .PERIOD(PER), .CHECK_LEN(CL), .WORD_W(WW), .CNT_W(CW)
    ) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .start    (start),
        .shift_en (shift_en),
        .ccff_tail(ccff_tail),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .first_err(first_err),
        .overflow (overflow),
        .rd       (rd_if)
    );

    always #5 prog_clk = ~prog_clk;

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    typedef struct {
        int lat;
        int err;
        int ferr;
        bit pas;
        bit ovf;
    } status_t;

    status_t    exp_st[$];
    logic [7:0] exp_w[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         start_edge = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    // Monitor: readback handshakes and done rising edges.
    logic       done_prev = 1'b0;
    logic [7:0] w;
    status_t    s;
    always @(negedge prog_clk) begin
        if (rd_if.rd_valid && rd_if.rd_ready) begin
            if (exp_w.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL word_unexpected: got %02h, required no word", rd_if.rd_data);
            end else begin
                w = exp_w.pop_front();
                chk("rd_data", 32'(rd_if.rd_data), 32'(w));
            end
        end
        if (done && !done_prev) begin
            if (exp_st.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected: got done=1, required no completion");
            end else begin
                s = exp_st.pop_front();
                chk("done_latency", 32'(cyc - start_edge), 32'(s.lat));
                chk("err_cnt", 32'(err_cnt), 32'(s.err));
                chk("first_err", 32'(first_err), 32'(s.ferr));
                chk("pass", 32'(pass), 32'(s.pas));
                chk("overflow", 32'(overflow), 32'(s.ovf));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
        done_prev = done;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_if.rd_valid), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_first_err"}, 32'(first_err), 32'hFFFF);
        chk({tag, "_rd_data"}, 32'(rd_if.rd_data), 32'd0);
    endtask

    task automatic push_st(input int lat, input int err, input int ferr, input bit pas, input bit ovf);
        status_t t;
        t.lat = lat; t.err = err; t.ferr = ferr; t.pas = pas; t.ovf = ovf;
        exp_st.push_back(t);
    endtask

    // tog: shift_en alternates 0/1; frc: check bit forced to 1 (-1 none); stk: tail stuck at 0;
    // rst_at: check bit on which pReset is applied instead (-1 none); restart: stray start mid-run.
    task automatic run(input bit tog, input int frc, input bit stk, input bit rdy,
                       input int rst_at, input bit restart);
        int k = 0;
        int j = 0;
        int i;
        bit fin = 1'b0;
        rd_if.rd_ready = rdy;
        start = 1'b1;
        shift_en = 1'b0;
        ccff_tail = 1'($urandom_range(0, 1));
        start_edge = cyc + 1;
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!fin && j < 200) begin
            start = (restart && j == 10);
            shift_en = tog ? (j % 2 == 1) : 1'b1;
            if (shift_en) begin
                if (k < BS) begin
                    ccff_tail = 1'($urandom_range(0, 1));
                end else begin
                    i = k - BS;
                    ccff_tail = (i % PER == PER - 1);
                    if (stk) ccff_tail = 1'b0;
                    if (i == frc) ccff_tail = 1'b1;
                    if (i == rst_at) pReset = 1'b1;
                end
                k++;
            end else begin
                ccff_tail = 1'($urandom_range(0, 1));
            end
            step();
            j++;
            if (pReset) begin
                pReset = 1'b0;
                fin = 1'b1;
            end else if (done) begin
                fin = 1'b1;
            end
        end
        start = 1'b0;
        shift_en = 1'b0;
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_timeout: got done=0 after %0d cycles, required done=1", j);
        end
    endtask

    initial begin
        pReset = 1'b1;
        start = 1'b0;
        shift_en = 1'b0;
        ccff_tail = 1'b0;
        rd_if.rd_ready = 1'b0;
        step();
        step();
        pReset = 1'b0;
        chk_reset("por");

        // Ideal chain.
        exp_w.push_back(8'h88); exp_w.push_back(8'h88);
        push_st(26, 0, 16'hFFFF, 1'b1, 1'b0);
        run(1'b0, -1, 1'b0, 1'b1, -1, 1'b0);
        step();

        // Check bit 5 forced high.
        exp_w.push_back(8'hA8); exp_w.push_back(8'h88);
        push_st(26, 1, 5, 1'b0, 1'b0);
        run(1'b0, 5, 1'b0, 1'b1, -1, 1'b0);
        step();

        // Tail stuck at 0.
        exp_w.push_back(8'h00); exp_w.push_back(8'h00);
        push_st(26, 4, 3, 1'b0, 1'b0);
        run(1'b0, -1, 1'b1, 1'b1, -1, 1'b0);
        step();

        // Consumer never ready: first word held, second dropped.
        exp_w.push_back(8'h88);
        push_st(26, 0, 16'hFFFF, 1'b0, 1'b1);
        run(1'b0, -1, 1'b0, 1'b0, -1, 1'b0);
        chk("held_rd_valid", 32'(rd_if.rd_valid), 32'd1);
        chk("held_rd_data", 32'(rd_if.rd_data), 32'h88);
        chk("held_overflow", 32'(overflow), 32'd1);
        rd_if.rd_ready = 1'b1;
        step();
        chk("drained_rd_valid", 32'(rd_if.rd_valid), 32'd0);
        chk("idle_done_held", 32'(done), 32'd1);

        // shift_en toggling, with a stray start during FLUSH.
        exp_w.push_back(8'h88); exp_w.push_back(8'h88);
        push_st(52, 0, 16'hFFFF, 1'b1, 1'b0);
        run(1'b1, -1, 1'b0, 1'b1, -1, 1'b1);
        step();

        // Reset on check bit 7 (the word-completing bit) after an error on bit 5.
        run(1'b0, 5, 1'b0, 1'b1, 7, 1'b0);
        chk_reset("midrst");
        step();
        chk("midrst_no_word", 32'(rd_if.rd_valid), 32'd0);

        // Clean rerun after reset.
        exp_w.push_back(8'h88); exp_w.push_back(8'h88);
        push_st(26, 0, 16'hFFFF, 1'b1, 1'b0);
        run(1'b0, -1, 1'b0, 1'b1, -1, 1'b0);
        step();
        step();

        chk("words_left", 32'(exp_w.size()), 32'd0);
        chk("status_left", 32'(exp_st.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required bench end");
        $fatal(1, "watchdog expired");
    end
endmodule
